fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx_if.sv | 11 +
 rtl/fifo_uart_tx.sv | 167 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side bus between the synchronous FIFO and its serial consumer.
interface fifo_uart_tx_if #(
   parameter int unsigned FIFO_WIDTH = 8
);
   logic                  fifo_empty;
   logic                  fifo_rd_en;
   logic [FIFO_WIDTH-1:0] fifo_rd_data;

   modport master (input fifo_empty, input fifo_rd_data, output fifo_rd_en);
   modport slave  (output fifo_empty, output fifo_rd_data, input fifo_rd_en);
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops words from the FIFO and transmits them as start/data(LSB first)/stop serial frames.
// Optional even-parity bit between data and stop when FIFO_TX_PARITY_EN is defined.
module fifo_uart_tx #(
   parameter int unsigned FIFO_WIDTH   = 8,
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   fifo_uart_tx_if.master         fifo,
   output logic                   tx,
   output logic                   busy,
   output logic                   frame_done
);
   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned BW = $clog2(FIFO_WIDTH + 1);
   localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(FIFO_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_LOAD,
      S_START,
      S_DATA,
`ifdef FIFO_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cyc_q, cyc_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [FIFO_WIDTH-1:0] shift_q, shift_d;
   logic                  tx_q, tx_d;
   logic                  rd_en_q, rd_en_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  bit_end;
`ifdef FIFO_TX_PARITY_EN
   logic                  parity_q, parity_d;
`endif

   assign bit_end = (cyc_q == CYC_LAST);

   // Next state, counters and shift register; outputs derive from next state so they register cleanly.
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      shift_d = shift_q;
`ifdef FIFO_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (enable && !fifo.fifo_empty) state_d = S_POP;
         end
         S_POP: state_d = S_LOAD;
         S_LOAD: begin
            shift_d = fifo.fifo_rd_data;
`ifdef FIFO_TX_PARITY_EN
            parity_d = ^fifo.fifo_rd_data;
`endif
            cyc_d   = '0;
            bit_d   = '0;
            state_d = S_START;
         end
         S_START: begin
            if (bit_end) begin
               cyc_d   = '0;
               state_d = S_DATA;
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cyc_d   = '0;
               shift_d = shift_q >> 1;
               if (bit_q == BIT_LAST) begin
                  bit_d = '0;
`ifdef FIFO_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end
`ifdef FIFO_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               cyc_d   = '0;
               state_d = S_STOP;
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               cyc_d   = '0;
               state_d = S_IDLE;
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cyc_d   = '0;
            bit_d   = '0;
         end
      endcase

      rd_en_d = (state_d == S_POP);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_STOP) && (cyc_d == CYC_LAST);
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef FIFO_TX_PARITY_EN
         S_PARITY: tx_d = parity_d;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cyc_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         rd_en_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef FIFO_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         rd_en_q <= rd_en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef FIFO_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign fifo.fifo_rd_en = rd_en_q;
   assign tx              = tx_q;
   assign busy            = busy_q;
   assign frame_done      = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small FIFO model on the read side.
module tb_fifo_uart_tx;
   localparam int CPB = 4;
`ifdef FIFO_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   typedef struct {
      logic [7:0] data;
      logic       par;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enable = 1'b1;
   logic tx, busy, frame_done;

   fifo_uart_tx_if #(.FIFO_WIDTH(8)) fif ();

   fifo_uart_tx #(.FIFO_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .fifo       (fif),
      .tx         (tx),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [64];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int rd_count = 0;
   int done_count = 0;
   int viol = 0;
   int n_checks = 0;
   int n_errors = 0;
   vec_t tbl [12];

   assign fif.fifo_empty = (wr_ptr == rd_ptr);

   // FIFO model: registered read data, valid the cycle after the strobe
   always @(posedge clk) begin
      if (fif.fifo_rd_en === 1'b1) begin
         rd_count++;
         if (wr_ptr == rd_ptr) viol++;
         else begin
            fif.fifo_rd_data <= mem[rd_ptr % 64];
            rd_ptr <= rd_ptr + 1;
         end
      end
      if (frame_done === 1'b1) done_count++;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   task automatic push(input logic [7:0] w);
      mem[wr_ptr % 64] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   function automatic logic [10:0] frame_of(input int idx);
`ifdef FIFO_TX_PARITY_EN
      return {1'b1, tbl[idx].par, tbl[idx].data, 1'b0};
`else
      return {2'b01, tbl[idx].data, 1'b0};
`endif
   endfunction

   // Waits for a start bit, then checks every cycle of the frame against the table entry.
   task automatic recv_frame(input int idx, input int drop_at, input int rst_at,
                             output int wait_n, output int busy_gap);
      logic [10:0] exp_f;
      int bit_err, done_err, busy_err;
      exp_f = frame_of(idx);
      wait_n = 0;
      busy_gap = 0;
      bit_err = 0;
      done_err = 0;
      busy_err = 0;
      do begin
         tick();
         wait_n++;
         if (tx !== 1'b0 && busy === 1'b1) busy_gap++;
      end while (tx !== 1'b0 && wait_n < 200);
      chk($sformatf("start_seen[%0d]", idx), 32'(tx), 32'd0);
      if (tx !== 1'b0) return;
      for (int c = 1; c <= NB * CPB; c++) begin
         if (c > 1) tick();
         if (tx !== exp_f[(c - 1) / CPB]) bit_err++;
         if (frame_done !== 1'(c == NB * CPB)) done_err++;
         if (busy !== 1'b1) busy_err++;
         if (c == drop_at) enable = 1'b0;
         if (c == rst_at) begin
            rst_n = 1'b0;
            break;
         end
      end
      chk($sformatf("frame_bits[%0d]", idx), 32'(bit_err), 32'd0);
      chk($sformatf("frame_done[%0d]", idx), 32'(done_err), 32'd0);
      chk($sformatf("frame_busy[%0d]", idx), 32'(busy_err), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int w, bg, cnt_a, cnt_b, cnt_c;
      tbl[0]  = '{8'hA5, 1'b0};
      tbl[1]  = '{8'hFF, 1'b0};
      tbl[2]  = '{8'hAA, 1'b0};
      tbl[3]  = '{8'h55, 1'b0};
      tbl[4]  = '{8'h0F, 1'b0};
      tbl[5]  = '{8'hF0, 1'b0};
      tbl[6]  = '{8'h01, 1'b1};
      tbl[7]  = '{8'h03, 1'b0};
      tbl[8]  = '{8'h07, 1'b1};
      tbl[9]  = '{8'h3C, 1'b0};
      tbl[10] = '{8'h0B, 1'b1};
      tbl[11] = '{8'h07, 1'b1};

      // reset held with a word waiting and enable high
      push(tbl[0].data);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_tx", 32'(tx), 32'd1);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_rd_en", 32'(fif.fifo_rd_en), 32'd0);
         chk("rst_done", 32'(frame_done), 32'd0);
      end
      rst_n = 1'b1;

      // single word, latency to start bit
      recv_frame(0, 0, 0, w, bg);
      chk("first_latency", 32'(w), 32'd3);
      chk("single_pops", 32'(rd_count), 32'd1);

      // back-to-back frames
      for (int i = 1; i <= 8; i++) push(tbl[i].data);
      for (int i = 1; i <= 8; i++) begin
         recv_frame(i, 0, 0, w, bg);
         if (i > 1) begin
            chk($sformatf("gap[%0d]", i), 32'(w), 32'd4);
            chk($sformatf("gap_busy[%0d]", i), 32'(bg), 32'd2);
         end
      end
      cnt_a = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (busy !== 1'b0) cnt_a++;
      end
      chk("b2b_busy_after", 32'(cnt_a), 32'd0);
      chk("b2b_pops", 32'(rd_count), 32'd9);
      chk("b2b_done", 32'(done_count), 32'd9);

      // empty FIFO with enable high
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (fif.fifo_rd_en !== 1'b0) cnt_a++;
         if (tx !== 1'b1) cnt_b++;
         if (busy !== 1'b0) cnt_c++;
      end
      chk("empty_rd_en", 32'(cnt_a), 32'd0);
      chk("empty_tx", 32'(cnt_b), 32'd0);
      chk("empty_busy", 32'(cnt_c), 32'd0);

      // enable dropped mid-DATA: frame completes, no further pop
      push(tbl[9].data);
      push(tbl[10].data);
      push(tbl[11].data);
      recv_frame(9, 10, 0, w, bg);
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (fif.fifo_rd_en !== 1'b0) cnt_a++;
         if (tx !== 1'b1) cnt_b++;
         if (busy !== 1'b0) cnt_c++;
      end
      chk("hold_rd_en", 32'(cnt_a), 32'd0);
      chk("hold_tx", 32'(cnt_b), 32'd0);
      chk("hold_busy", 32'(cnt_c), 32'd0);
      chk("hold_pops", 32'(rd_count), 32'd10);
      enable = 1'b1;
      tick();
      chk("reenable_pop", 32'(fif.fifo_rd_en), 32'd1);

      // reset during data bit 3: popped word dropped, next word sent
      recv_frame(10, 0, 18, w, bg);
      chk("reenable_latency", 32'(w), 32'd2);
      tick();
      chk("midrst_tx", 32'(tx), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_rd_en", 32'(fif.fifo_rd_en), 32'd0);
      rst_n = 1'b1;
      recv_frame(11, 0, 0, w, bg);
      chk("postrst_latency", 32'(w), 32'd3);
      for (int i = 0; i < 5; i++) tick();
      chk("total_pops", 32'(rd_count), 32'd12);
      chk("total_done", 32'(done_count), 32'd11);
      chk("empty_pop_viol", 32'(viol), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
